nand_phy_rd_capture: RTL and testbench



---
 rtl/nand_phy_pkg.sv | 22 ++
 rtl/nand_phy_rd_fifo.sv | 86 ++++++++
 rtl/nand_phy_rd_capture.sv | 178 +++++++++++++++++
 tb/tb_nand_phy_rd_capture.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_phy_pkg.sv
// rtl/nand_phy_pkg.sv - shared types and constants for the NAND PHY read-capture path
// Contents: rdcap_state_t capture FSM states, OUT_W default packed-word width,
//           out_width() helper for parameterised instances, PATTERN_SEED start byte
//           for the optional incrementing-pattern checker.
package nand_phy_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } rdcap_state_t;

    localparam int DQ_WIDTH_DFLT        = 8;
    localparam int CYCLES_PER_WORD_DFLT = 4;
    localparam int OUT_W                = 2 * DQ_WIDTH_DFLT * CYCLES_PER_WORD_DFLT;

    localparam logic [7:0] PATTERN_SEED = 8'h00;

    function automatic int out_width(input int dq_width, input int cycles_per_word);
        return 2 * dq_width * cycles_per_word;
    endfunction

endpackage

// File: rtl/nand_phy_rd_fifo.sv
// rtl/nand_phy_rd_fifo.sv - synchronous FIFO with a registered output stage
// Ports: clk/rst (sync, active-high); push/push_data write side (write ignored
//        when full unless a pop happens in the same cycle); full flag;
//        out_valid/out_ready/out_data read side driven straight from flops.
// The output register counts as one of the DEPTH entries, so total storage is
// DEPTH words; the array only ever holds up to DEPTH-1 of them.
module nand_phy_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      mem_cnt_q;
    logic [AW:0]      total;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             pop;
    logic             push_ok;
    logic             load_out;
    logic             from_mem;
    logic             bypass;
    logic             to_mem;

    assign total     = mem_cnt_q + {{AW{1'b0}}, valid_q};
    assign full      = (total == (AW + 1)'(DEPTH));
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        pop      = valid_q && out_ready;
        push_ok  = push && (!full || pop);
        load_out = !valid_q || pop;
        from_mem = load_out && (mem_cnt_q != '0);
        // An empty array lets a new word go straight into the output register,
        // which gives the one-cycle write-to-valid latency.
        bypass   = load_out && (mem_cnt_q == '0) && push_ok;
        to_mem   = push_ok && !bypass;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            if (to_mem) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (from_mem) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
                valid_q  <= 1'b1;
            end else if (bypass) begin
                data_q  <= push_data;
                valid_q <= 1'b1;
            end else if (load_out) begin
                valid_q <= 1'b0;
            end
            if (to_mem && !from_mem) begin
                mem_cnt_q <= mem_cnt_q + 1'b1;
            end else if (from_mem && !to_mem) begin
                mem_cnt_q <= mem_cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nand_phy_rd_capture.sv
// rtl/nand_phy_rd_capture.sv - NAND read-data capture: beat qualification, word packing, output FIFO
// Ports: clk90/rst90 (sync, active-high); rd_start/rd_cycles arm one burst;
//        dqs_active controller strobe; rd_data_rise/rd_data_fall ISERDES Q2/Q1;
//        out_data/out_keep/out_last/out_valid/out_ready output stream;
//        busy burst in progress; overflow sticky drop flag; chk_err_cnt pattern errors.
// Optional feature macro: NAND_RDCAP_PATTERN_CHK_EN (incrementing-pattern checker).
module nand_phy_rd_capture
    import nand_phy_pkg::*;
#(
    parameter int DQ_WIDTH        = 8,
    parameter int CYCLES_PER_WORD = 4,
    parameter int CAPTURE_LATENCY = 2,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                  clk90,
    input  logic                                  rst90,
    input  logic                                  rd_start,
    input  logic [15:0]                           rd_cycles,
    input  logic                                  dqs_active,
    input  logic [DQ_WIDTH-1:0]                   rd_data_rise,
    input  logic [DQ_WIDTH-1:0]                   rd_data_fall,
    output logic [2*DQ_WIDTH*CYCLES_PER_WORD-1:0] out_data,
    output logic [2*CYCLES_PER_WORD-1:0]          out_keep,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  overflow,
    output logic [15:0]                           chk_err_cnt
);

    localparam int WORD_W  = out_width(DQ_WIDTH, CYCLES_PER_WORD);
    localparam int KEEP_W  = 2 * CYCLES_PER_WORD;
    localparam int PAIR_W  = $clog2(CYCLES_PER_WORD) + 1;
    localparam int ENTRY_W = WORD_W + KEEP_W + 1;

    rdcap_state_t               state_q, state_d;
    logic [CAPTURE_LATENCY-1:0] dqs_dly_q;
    logic                       beat_q;
    logic [15:0]                remaining_q, remaining_d;
    logic [PAIR_W-1:0]          pair_q, pair_d;
    logic [WORD_W-1:0]          pack_q, pack_d, word_w;
    logic [KEEP_W-1:0]          keep_q, keep_d, keep_w;
    logic                       overflow_q, overflow_d;
    logic                       push;
    logic                       push_last;
    logic                       fifo_full;
    logic                       pop;
    logic [ENTRY_W-1:0]         fifo_out;

    // dqs_active delayed to line up with the ISERDES Q outputs it qualifies.
    assign beat_q   = dqs_dly_q[CAPTURE_LATENCY-1];
    assign pop      = out_valid && out_ready;
    assign busy     = (state_q == CAPTURE);
    assign overflow = overflow_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pair_d      = pair_q;
        pack_d      = pack_q;
        keep_d      = keep_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        push_last   = 1'b0;
        // Candidate word with this beat merged in: rise byte lands below fall byte.
        word_w = pack_q;
        word_w[pair_q*2*DQ_WIDTH +: 2*DQ_WIDTH] = {rd_data_fall, rd_data_rise};
        keep_w = keep_q;
        keep_w[pair_q*2 +: 2] = 2'b11;

        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    remaining_d = (rd_cycles == 16'd0) ? 16'd1 : rd_cycles;
                    overflow_d  = 1'b0;
                    pair_d      = '0;
                    pack_d      = '0;
                    keep_d      = '0;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (beat_q) begin
                    remaining_d = remaining_q - 16'd1;
                    if ((pair_q == PAIR_W'(CYCLES_PER_WORD - 1)) || (remaining_q == 16'd1)) begin
                        push      = 1'b1;
                        push_last = (remaining_q == 16'd1);
                        // Clearing the pack register is what zero-pads a short final word.
                        pair_d    = '0;
                        pack_d    = '0;
                        keep_d    = '0;
                        if (push_last) begin
                            state_d = IDLE;
                        end
                    end else begin
                        pair_d = pair_q + 1'b1;
                        pack_d = word_w;
                        keep_d = keep_w;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A dropped word does not stop the burst; only the flag records it.
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk90) begin
        if (rst90) begin
            state_q     <= IDLE;
            dqs_dly_q   <= '0;
            remaining_q <= '0;
            pair_q      <= '0;
            pack_q      <= '0;
            keep_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dqs_dly_q   <= (dqs_dly_q << 1) | CAPTURE_LATENCY'(dqs_active);
            remaining_q <= remaining_d;
            pair_q      <= pair_d;
            pack_q      <= pack_d;
            keep_q      <= keep_d;
            overflow_q  <= overflow_d;
        end
    end

    nand_phy_rd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk90),
        .rst       (rst90),
        .push      (push),
        .push_data ({push_last, keep_w, word_w}),
        .full      (fifo_full),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (fifo_out)
    );

    assign {out_last, out_keep, out_data} = fifo_out;

`ifdef NAND_RDCAP_PATTERN_CHK_EN
    logic [DQ_WIDTH-1:0] pat_exp_q;
    logic [15:0]         err_q;
    logic [1:0]          miss;
    logic [16:0]         err_sum;

    always_comb begin
        miss    = 2'(rd_data_rise != pat_exp_q) +
                  2'(rd_data_fall != (pat_exp_q + DQ_WIDTH'(1)));
        err_sum = {1'b0, err_q} + 17'(miss);
    end

    always_ff @(posedge clk90) begin
        if (rst90) begin
            pat_exp_q <= '0;
            err_q     <= '0;
        end else if ((state_q == IDLE) && rd_start) begin
            pat_exp_q <= DQ_WIDTH'(PATTERN_SEED);
            err_q     <= '0;
        end else if ((state_q == CAPTURE) && beat_q) begin
            pat_exp_q <= pat_exp_q + DQ_WIDTH'(2);
            err_q     <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign chk_err_cnt = err_q;
`else
    assign chk_err_cnt = '0;
`endif

endmodule

// File: tb/tb_nand_phy_rd_capture.sv
// tb/tb_nand_phy_rd_capture.sv - self-checking bench for nand_phy_rd_capture
module tb_nand_phy_rd_capture;
    import nand_phy_pkg::*;

    localparam int DQ    = 8;
    localparam int CPW   = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int W     = OUT_W;
    localparam int KW    = 2 * CPW;

    logic          clk90 = 1'b0;
    logic          rst90;
    logic          rd_start;
    logic [15:0]   rd_cycles;
    logic          dqs_active;
    logic [DQ-1:0] rd_data_rise;
    logic [DQ-1:0] rd_data_fall;
    logic [W-1:0]  out_data;
    logic [KW-1:0] out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic [15:0]   chk_err_cnt;

    always #5 clk90 = ~clk90;

    nand_phy_rd_capture #(
        .DQ_WIDTH        (DQ),
        .CYCLES_PER_WORD (CPW),
        .CAPTURE_LATENCY (LAT),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk90        (clk90),
        .rst90        (rst90),
        .rd_start     (rd_start),
        .rd_cycles    (rd_cycles),
        .dqs_active   (dqs_active),
        .rd_data_rise (rd_data_rise),
        .rd_data_fall (rd_data_fall),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .overflow     (overflow),
        .chk_err_cnt  (chk_err_cnt)
    );

    int n_tot = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int first_valid = -1;
    int j4 = 0;

    // stimulus side
    bit           drv_q[$];
    byte unsigned src[$];

    // reference model: FIFO contents as a queue of whole words
    bit           m_init = 1'b0;
    bit           m_busy;
    int           m_rem;
    bit           m_ovf;
    int           m_err;
    int           m_pat;
    bit           m_dly[$];
    byte unsigned m_bytes[$];
    logic [W-1:0]  mq_d[$];
    logic [KW-1:0] mq_k[$];
    bit            mq_l[$];

    // words actually delivered by the DUT
    logic [W-1:0]  got_d[$];
    logic [KW-1:0] got_k[$];
    bit            got_l[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic model_step();
        bit beat;
        bit pop;
        int pre;
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        if (rst90) begin
            m_init = 1'b1; m_busy = 1'b0; m_rem = 0; m_ovf = 1'b0; m_err = 0; m_pat = 0;
            m_bytes.delete(); mq_d.delete(); mq_k.delete(); mq_l.delete();
            m_dly.delete();
            repeat (LAT) m_dly.push_back(1'b0);
            return;
        end
        if (!m_init) return;
        beat = m_dly.pop_front();
        m_dly.push_back(dqs_active);
        pre = mq_d.size();
        pop = (pre != 0) && out_ready;
        if (pop) begin
            void'(mq_d.pop_front()); void'(mq_k.pop_front()); void'(mq_l.pop_front());
        end
        if (!m_busy) begin
            if (rd_start) begin
                m_busy = 1'b1;
                m_rem  = (rd_cycles == 16'd0) ? 1 : int'(rd_cycles);
                m_ovf  = 1'b0; m_err = 0; m_pat = 0;
                m_bytes.delete();
            end
        end else if (beat) begin
            m_bytes.push_back(rd_data_rise);
            m_bytes.push_back(rd_data_fall);
`ifdef NAND_RDCAP_PATTERN_CHK_EN
            if (rd_data_rise != 8'(m_pat)) m_err++;
            if (rd_data_fall != 8'(m_pat + 1)) m_err++;
            if (m_err > 65535) m_err = 65535;
            m_pat = (m_pat + 2) % 256;
`endif
            m_rem--;
            if (m_bytes.size() == 2 * CPW || m_rem == 0) begin
                d = '0; k = '0;
                foreach (m_bytes[i]) begin
                    d[8*i +: 8] = m_bytes[i];
                    k[i] = 1'b1;
                end
                if (pre == DEPTH && !pop) m_ovf = 1'b1;
                else begin
                    mq_d.push_back(d); mq_k.push_back(k); mq_l.push_back(m_rem == 0);
                end
                m_bytes.delete();
                if (m_rem == 0) m_busy = 1'b0;
            end
        end
    endtask

    task automatic compare();
        if (!m_init) return;
        check("out_valid", out_valid, mq_d.size() != 0);
        if (mq_d.size() != 0) begin
            check("out_data", out_data, mq_d[0]);
            check("out_keep", out_keep, mq_k[0]);
            check("out_last", out_last, mq_l[0]);
        end
        check("busy", busy, m_busy);
        check("overflow", overflow, m_ovf);
        check("chk_err_cnt", chk_err_cnt, m_err);
        if (out_valid && first_valid < 0) first_valid = cyc_n;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data); got_k.push_back(out_keep); got_l.push_back(out_last);
        end
    endtask

    task automatic cycle(input bit start, input logic [15:0] cyc, input bit dqs,
                         input bit ready, input bit rst);
        bit bd;
        @(posedge clk90);
        #1;
        cyc_n++;
        rd_start = start; rd_cycles = cyc; dqs_active = dqs; out_ready = ready; rst90 = rst;
        bd = drv_q.pop_front();
        drv_q.push_back(dqs);
        if (bd && src.size() >= 2) begin
            rd_data_rise = src.pop_front();
            rd_data_fall = src.pop_front();
        end else begin
            rd_data_rise = 8'($urandom);
            rd_data_fall = 8'($urandom);
        end
        @(negedge clk90);
        compare();
        model_step();
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
            if (!m_busy && mq_d.size() == 0) break;
        end
    endtask

    task automatic load_src(input int n, input int bad);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back((i == bad) ? 8'hFF : 8'(i));
    endtask

    task automatic clear_got();
        got_d.delete(); got_k.delete(); got_l.delete();
    endtask

    task automatic burst(input int n, input int pairs, input bit gapped);
        cycle(1'b1, 16'(pairs), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 16'd0, gapped ? (i % 2 == 0) : 1'b1, 1'b1, 1'b0);
            if (i == 3) j4 = cyc_n;
        end
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst90 = 1'b1; rd_start = 1'b0; rd_cycles = '0; dqs_active = 1'b0;
        out_ready = 1'b0; rd_data_rise = '0; rd_data_fall = '0;
        repeat (LAT) drv_q.push_back(1'b0);
        repeat (3) cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_overflow", overflow, 1'b0);

        // two full words, latency from the 4th strobe
        load_src(16, -1); clear_got(); first_valid = -1;
        burst(8, 8, 1'b0);
        check("t1_words", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("t1_w0", got_d[0], 64'h0706050403020100);
            check("t1_w1", got_d[1], 64'h0F0E0D0C0B0A0908);
            check("t1_k0", got_k[0], 8'hFF);
            check("t1_k1", got_k[1], 8'hFF);
            check("t1_l0", got_l[0], 1'b0);
            check("t1_l1", got_l[1], 1'b1);
        end
        check("t1_latency", first_valid - j4, 3);

        // partial final word
        load_src(10, -1); clear_got();
        burst(5, 5, 1'b0);
        check("t2_words", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("t2_w1", got_d[1], 64'h0000000000000908);
            check("t2_k1", got_k[1], 8'h03);
            check("t2_l1", got_l[1], 1'b1);
        end

        // gapped strobe
        load_src(8, -1); clear_got();
        burst(7, 4, 1'b1);
        check("t3_words", got_d.size(), 1);
        if (got_d.size() == 1) begin
            check("t3_w0", got_d[0], 64'h0706050403020100);
            check("t3_l0", got_l[0], 1'b1);
        end

        // overflow with a stalled consumer
        src.delete();
        cycle(1'b1, 16'd40, 1'b0, 1'b0, 1'b0);
        repeat (40) cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_busy", busy, 1'b0);
        clear_got();
        drain();
        check("ovf_held", got_d.size(), 8);
        cycle(1'b1, 16'd4, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        check("ovf_clear", overflow, 1'b0);
        repeat (4) cycle(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        drain();

        // reset mid-burst, then a fresh burst
        load_src(8, -1);
        cycle(1'b1, 16'd8, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        load_src(8, -1); clear_got();
        burst(4, 4, 1'b0);
        check("t5_words", got_d.size(), 1);
        if (got_d.size() == 1) begin
            check("t5_w0", got_d[0], 64'h0706050403020100);
            check("t5_k0", got_k[0], 8'hFF);
        end

        // corrupted byte 5
        load_src(8, 5); clear_got();
        burst(4, 4, 1'b0);
        check("t6_words", got_d.size(), 1);
        if (got_d.size() == 1) check("t6_w0", got_d[0], 64'h0706FF0403020100);
`ifdef NAND_RDCAP_PATTERN_CHK_EN
        check("t6_chk_err", chk_err_cnt, 16'd1);
`else
        check("t6_chk_err", chk_err_cnt, 16'd0);
`endif

        // randomized bursts, stray starts, back-pressure and rare resets
        src.delete();
        for (int b = 0; b < 40; b++) begin
            int len;
            int rp;
            len = $urandom_range(0, 24);
            rp  = $urandom_range(2, 10);
            cycle(1'b1, 16'(len), 1'b0, 1'b1, 1'b0);
            for (int k = 0; k < 2 * len + 30; k++) begin
                cycle($urandom_range(0, 24) == 0, 16'($urandom_range(0, 20)),
                      $urandom_range(0, 9) < 7, $urandom_range(0, 9) < rp,
                      $urandom_range(0, 399) == 0);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
